mux4x1_rr_sched: RTL and testbench

MUX4X1_RR_SCHED -- requirements
Module: mux4x1_rr_sched

---
 rtl/mux4x1_rr_sched.sv | 143 ++++++++++++++
 tb/tb_mux4x1_rr_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4x1_rr_sched.sv
// Four-lane round-robin packet mux with one output register stage and packet locking.
// Optional per-lane completed-packet counters are enabled by defining MUX4X1_RR_SCHED_STATS_EN.
//
// state | meaning
// ARB   | round-robin search from ptr for the next packet head
// LOCK  | mid-packet; only lane lock_id may be granted
module mux4x1_rr_sched #(
    parameter int DATA_W = 8,
    parameter int STAT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            in_last,
    output logic [3:0]            gnt,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic [1:0]            out_sel,
    input  logic                  out_ready
`ifdef MUX4X1_RR_SCHED_STATS_EN
    ,
    input  logic [1:0]            stat_sel,
    output logic [STAT_W-1:0]     stat_cnt
`endif
);

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          lock_id_q, lock_id_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [1:0]          out_sel_q, out_sel_d;

    logic [3:0][DATA_W-1:0] lane_data;
    logic                slot_free;
    logic                sel_valid;
    logic [1:0]          sel_lane;
    logic [1:0]          idx;
    logic                accept;
    logic                acc_last;

    assign lane_data = in_data;
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        sel_valid = 1'b0;
        sel_lane  = ptr_q;
        idx       = ptr_q;
        if (state_q == LOCK) begin
            sel_lane  = lock_id_q;
            sel_valid = req[lock_id_q];
        end else begin
            // Descending scan so the lane closest to ptr is the one left standing.
            for (int k = 3; k >= 0; k--) begin
                idx = ptr_q + 2'(k);
                if (req[idx]) begin
                    sel_valid = 1'b1;
                    sel_lane  = idx;
                end
            end
        end
        gnt = 4'b0000;
        if (rst_n && slot_free && sel_valid) begin
            gnt[sel_lane] = 1'b1;
        end
    end

    assign accept   = |gnt;
    assign acc_last = in_last[sel_lane];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_id_d   = lock_id_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_data[sel_lane];
            out_last_d  = acc_last;
            out_sel_d   = sel_lane;
            if (acc_last) begin
                state_d = ARB;
                ptr_d   = sel_lane + 2'd1;
            end else begin
                state_d   = LOCK;
                lock_id_d = sel_lane;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            ptr_q       <= 2'd0;
            lock_id_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_id_q   <= lock_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

`ifdef MUX4X1_RR_SCHED_STATS_EN
    logic [3:0][STAT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (accept && acc_last && !(&stat_q[sel_lane])) begin
            stat_q[sel_lane] <= stat_q[sel_lane] + 1'b1;
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`else
    logic [STAT_W-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_mux4x1_rr_sched.sv
// Self-checking bench for mux4x1_rr_sched: directed scenarios then random traffic
// against a packet-level reference model; define MUX4X1_RR_SCHED_STATS_EN to cover the counters.
`timescale 1ns/1ps
module tb_mux4x1_rr_sched;

    localparam int W  = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [4*W-1:0] in_data;
    logic [3:0]    in_last;
    logic [3:0]    gnt;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [1:0]    out_sel;
    logic          out_ready;
`ifdef MUX4X1_RR_SCHED_STATS_EN
    logic [1:0]    stat_sel;
    logic [SW-1:0] stat_cnt;
`endif

    mux4x1_rr_sched #(.DATA_W(W), .STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .in_last(in_last),
        .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_sel(out_sel), .out_ready(out_ready)
`ifdef MUX4X1_RR_SCHED_STATS_EN
        , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: packet-level view of the scheduler.
    bit       m_locked;
    int       m_lock;
    int       m_ptr;
    bit       m_ov;
    int       m_od;
    bit       m_ol;
    int       m_os;
    int       m_stat [4];
    logic [3:0] last_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (rst_n !== 1'b1) return g;
        if (m_ov && !out_ready) return g;
        if (m_locked) begin
            if (req[m_lock]) g[m_lock] = 1'b1;
            return g;
        end
        for (int k = 0; k < 4; k++) begin
            if (req[(m_ptr + k) % 4]) begin
                g[(m_ptr + k) % 4] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_lock = 0; m_ptr = 0;
        m_ov = 0; m_od = 0; m_ol = 0; m_os = 0;
        for (int i = 0; i < 4; i++) m_stat[i] = 0;
    endtask

    task automatic model_update(input logic [3:0] eg);
        int g;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (eg != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) g = i;
            m_ov = 1;
            m_od = int'(in_data[g*W +: W]);
            m_ol = in_last[g];
            m_os = g;
            if (in_last[g]) begin
                m_locked = 0;
                m_ptr = (g + 1) % 4;
                if (m_stat[g] < (1 << SW) - 1) m_stat[g]++;
            end else begin
                m_locked = 1;
                m_lock = g;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
    endtask

    // One clock: gnt checked mid-cycle, registered outputs checked just after the edge.
    task automatic cycle();
        logic [3:0] eg;
        @(negedge clk);
        eg = model_gnt();
        last_gnt = gnt;
        chk("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        model_update(eg);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_last", 32'(out_last), 32'(m_ol));
            chk("out_sel",  32'(out_sel),  32'(m_os));
        end
    endtask

    task automatic set_data_rand();
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'($urandom);
    endtask

    int exp_sel34 [5];
    logic [3:0] exp_gnt34 [5];

    initial begin
        exp_gnt34 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_sel34 = '{0, 1, 2, 3, 0};
        model_reset();
        last_gnt = 4'b0000;
        rst_n = 1'b0; req = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        set_data_rand();
`ifdef MUX4X1_RR_SCHED_STATS_EN
        stat_sel = 2'd0;
`endif
        // Reset: gnt held at 0 while asserted, registers cleared.
        cycle();
        cycle();
        chk("rst_gnt", 32'(last_gnt), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);

        // Round robin with single-beat packets on every lane.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_data_rand();
            cycle();
            chk("rr_gnt", 32'(last_gnt), 32'(exp_gnt34[i]));
            chk("rr_sel", 32'(out_sel), 32'(exp_sel34[i]));
        end

        // Move ptr to 2 with a lane-1 packet, then a 3-beat packet on lane 2.
        req = 4'b0010; in_last = 4'b1111; set_data_rand();
        cycle();
        chk("pkt_pre", 32'(last_gnt), 32'h2);
        req = 4'b0111; in_last = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_last = 4'b0100;
            set_data_rand();
            cycle();
            chk("pkt_lane2", 32'(last_gnt), 32'h4);
        end
        req = 4'b0011; in_last = 4'b1111; set_data_rand();
        cycle();
        chk("pkt_after", 32'(last_gnt), 32'h1);

        // Stall with 8'hA5 held on the output.
        req = 4'b0010; in_last = 4'b1111; in_data = {4{8'hA5}};
        cycle();
        out_ready = 1'b0; req = 4'b1111; set_data_rand();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_gnt", 32'(last_gnt), 32'h0);
            chk("stall_data", 32'(out_data), 32'hA5);
            chk("stall_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        cycle();
        chk("stall_release", 32'(last_gnt), 32'h4);

        // Lane 1 locked; its req drops while lane 3 waits.
        req = 4'b0010; in_last = 4'b0000; set_data_rand();
        cycle();
        chk("lock_start", 32'(last_gnt), 32'h2);
        req = 4'b1000;
        cycle();
        chk("lock_idle0", 32'(last_gnt), 32'h0);
        cycle();
        chk("lock_idle1", 32'(last_gnt), 32'h0);
        req = 4'b1010; in_last = 4'b0010;
        cycle();
        chk("lock_resume", 32'(last_gnt), 32'h2);

        // Reset mid-lock with a beat held.
        req = 4'b0100; in_last = 4'b0000; out_ready = 1'b0;
        cycle();
        chk("mid_lock", 32'(out_valid), 32'h1);
        rst_n = 1'b0; req = 4'b1111;
        cycle();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1; out_ready = 1'b1; in_last = 4'b1111;
        cycle();
        chk("mid_rst_lane0", 32'(last_gnt), 32'h1);

`ifdef MUX4X1_RR_SCHED_STATS_EN
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; req = 4'b1000; in_last = 4'b1000;
        for (int i = 0; i < 5; i++) cycle();
        stat_sel = 2'd3;
        #1;
        chk("stat_sat", 32'(stat_cnt), 32'h3);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req       = 4'($urandom);
            in_last   = 4'($urandom) | 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            set_data_rand();
            cycle();
`ifdef MUX4X1_RR_SCHED_STATS_EN
            stat_sel = 2'($urandom);
            #1;
            chk("stat_rand", 32'(stat_cnt), 32'(m_stat[stat_sel]));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
